// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM states,
// bus-owner codes and the full-word byte-enable used for reads.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_IF   = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-cycle watchdog: cleared on each grant, counts cycles without mem_ready
// and flags the cycle in which the count reaches TIMEOUT.
module mem_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise saturating increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the edge that would bring the count to TIMEOUT
  assign expired = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter sharing one memory bus between instruction fetch and
// load/store, with data priority, fetch anti-starvation and timeout recovery.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  owner
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e state_q, state_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [1:0]    owner_q, owner_d;
  logic          if_ack_q, if_ack_d;
  logic          if_err_q, if_err_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic [SW-1:0] starve_q, starve_d;

  logic pick_d;
  logic grant_if;
  logic grant_d;
  logic done_ok;
  logic done_to;
  logic wdog_clr;
  logic wdog_en;
  logic wdog_expired;

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  assign wdog_clr = grant_if | grant_d;
  assign wdog_en  = (state_q != IDLE) && !mem_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arbitration in IDLE, completion or timeout while busy.
  // Preference uses the raw requests; a requester being acked this cycle
  // cannot be granted, so its preferred slot simply waits one cycle.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    pick_d   = d_req && !(if_req && (starve_q >= STARVE_LIM));
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          if (!d_ack_q) begin
            grant_d = 1'b1;
            state_d = BUSY_D;
          end else begin
            state_d = IDLE;
          end
        end else if (if_req) begin
          if (!if_ack_q) begin
            grant_if = 1'b1;
            state_d  = BUSY_IF;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (wdog_expired) begin
          done_to = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: command capture on grant, response capture on completion
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    owner_d     = owner_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = word_addr(d_addr);
      mem_wdata_d = d_wdata;
      mem_be_d    = d_we ? d_be : BE_FULL;
      owner_d     = OWNER_D;
      if (if_req && (starve_q < STARVE_LIM)) begin
        starve_d = starve_q + SW'(1);
      end else begin
        starve_d = starve_q;
      end
    end else if (grant_if) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = word_addr(if_addr);
      mem_wdata_d = 32'd0;
      mem_be_d    = BE_FULL;
      owner_d     = OWNER_IF;
      starve_d    = '0;
    end else if (done_ok) begin
      mem_req_d = 1'b0;
      owner_d   = OWNER_NONE;
      if (state_q == BUSY_IF) begin
        if_ack_d   = 1'b1;
        if_rdata_d = mem_rdata;
      end else begin
        d_ack_d = 1'b1;
        if (!mem_we_q) begin
          d_rdata_d = mem_rdata;
        end else begin
          d_rdata_d = d_rdata_q;
        end
      end
    end else if (done_to) begin
      mem_req_d = 1'b0;
      owner_d   = OWNER_NONE;
      if (state_q == BUSY_IF) begin
        if_ack_d = 1'b1;
        if_err_d = 1'b1;
      end else begin
        d_ack_d = 1'b1;
        d_err_d = 1'b1;
      end
    end else begin
      mem_req_d = mem_req_q;
    end
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      owner_q     <= OWNER_NONE;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      starve_q    <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      owner_q     <= owner_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign owner     = owner_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level arbitration model.
module tb_riscv_mem_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 8;
  localparam logic [1:0] O_NONE = 2'b00;
  localparam logic [1:0] O_IF   = 2'b01;
  localparam logic [1:0] O_D    = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_d_rdata  = 32'd0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  function automatic logic [139:0] outs_vec();
    return {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack,
            if_err, d_err, if_rdata, d_rdata, owner};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; mem_rdata = 32'd0;
    #12;
    checks++;
    if (outs_vec() !== 140'd0) begin
      errors++; $display("FAIL reset_outs got=%h want=0", outs_vec());
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (outs_vec() !== 140'd0) begin
      errors++; $display("FAIL reset_idle got=%h want=0", outs_vec());
    end
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0103; mem_ready = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100 || mem_be !== 4'hF ||
        mem_we !== 1'b0 || owner !== O_IF || if_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_cmd req=%b addr=%h be=%h we=%b own=%b want 1/100/f/0/01",
               mem_req, mem_addr, mem_be, mem_we, owner);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h0050_0093 ||
        mem_req !== 1'b0 || owner !== O_NONE) begin
      errors++;
      $display("FAIL fetch_ack ack=%b err=%b rdata=%h req=%b own=%b want 1/0/00500093/0/00",
               if_ack, if_err, if_rdata, mem_req, owner);
    end
    exp_if_rdata = 32'h0050_0093;
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    checks++;
    if (if_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_ack_pulse ack=%b want 0", if_ack);
    end
  endtask

  task automatic test_contention();
    logic [1:0] seq [10];
    logic [1:0] prev_own;
    logic [1:0] want;
    int n;
    n = 0;
    prev_own = O_NONE;
    d_we = 1'b0; d_addr = 32'h0000_0404; if_addr = 32'h0000_0808;
    mem_rdata = 32'hCAFE_0001; mem_ready = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 80 && n < 10; c++) begin
      tick();
      if (owner !== O_NONE && prev_own === O_NONE) begin
        seq[n] = owner;
        n++;
      end
      prev_own = owner;
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL contention_grants got=%0d want=10", n);
    end
    for (int i = 0; i < n; i++) begin
      want = ((i % (SMAX + 1)) == SMAX) ? O_IF : O_D;
      checks++;
      if (seq[i] !== want) begin
        errors++; $display("FAIL contention_order idx=%0d got=%b want=%b", i, seq[i], want);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    exp_if_rdata = 32'hCAFE_0001;
    exp_d_rdata  = 32'hCAFE_0001;
  endtask

  task automatic test_store();
    logic [71:0] exp_cmd;
    exp_cmd = {1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, O_D};
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_be = 4'b0011;
    d_wdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, owner} !== exp_cmd) begin
      errors++;
      $display("FAIL store_cmd got=%h want=%h",
               {mem_req, mem_we, mem_addr, mem_wdata, mem_be, owner}, exp_cmd);
    end
    d_addr = 32'hFFFF_FFFC; d_wdata = 32'd0; d_be = 4'hF; d_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, owner} !== exp_cmd || d_ack !== 1'b0) begin
        errors++;
        $display("FAIL store_stable cyc=%0d got=%h ack=%b want=%h ack=0", i,
                 {mem_req, mem_we, mem_addr, mem_wdata, mem_be, owner}, d_ack, exp_cmd);
      end
    end
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== exp_d_rdata || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_ack ack=%b err=%b rdata=%h req=%b want 1/0/%h/0",
               d_ack, d_err, d_rdata, mem_req, exp_d_rdata);
    end
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; mem_ready = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || owner !== O_D) begin
      errors++; $display("FAIL timeout_grant req=%b own=%b want 1/10", mem_req, owner);
    end
    for (int n = 1; n <= TMO; n++) begin
      tick();
      checks++;
      if (n < TMO) begin
        if (d_ack !== 1'b0 || mem_req !== 1'b1) begin
          errors++; $display("FAIL timeout_wait n=%0d ack=%b req=%b want 0/1", n, d_ack, mem_req);
        end
      end else begin
        if (d_ack !== 1'b1 || d_err !== 1'b1 || mem_req !== 1'b0 ||
            owner !== O_NONE || d_rdata !== exp_d_rdata) begin
          errors++;
          $display("FAIL timeout_end ack=%b err=%b req=%b own=%b rdata=%h want 1/1/0/00/%h",
                   d_ack, d_err, mem_req, owner, d_rdata, exp_d_rdata);
        end
      end
    end
    d_req = 1'b0;
    tick();
    checks++;
    if (d_ack !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse ack=%b err=%b want 0/0", d_ack, d_err);
    end
  endtask

  task automatic test_ready_at_limit();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0304; mem_ready = 1'b0;
    tick();
    for (int n = 1; n < TMO; n++) tick();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL limit_ready ack=%b err=%b rdata=%h want 1/0/0badf00d", d_ack, d_err, d_rdata);
    end
    exp_d_rdata = 32'h0BAD_F00D;
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen_ack;
    seen_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; mem_ready = 1'b0;
    tick(); tick();
    checks++;
    if (owner !== O_D) begin
      errors++; $display("FAIL rstmid_busy own=%b want 10", owner);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs_vec() !== 140'd0) begin
      errors++; $display("FAIL rstmid_async got=%h want=0", outs_vec());
    end
    d_req = 1'b0;
    @(posedge clk);
    #1;
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_ack !== 1'b0) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack !== 1'b0) begin
      errors++; $display("FAIL rstmid_noack saw d_ack=1 want none");
    end
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;
    if_req = 1'b1; if_addr = 32'h0000_0046;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h1111_2222) begin
      errors++;
      $display("FAIL rstmid_fetch ack=%b err=%b rdata=%h want 1/0/11112222", if_ack, if_err, if_rdata);
    end
    exp_if_rdata = 32'h1111_2222;
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  // Random requesters and memory; the model tracks the starvation count and
  // which requester is being acked, and predicts every observed cycle.
  task automatic test_random();
    int st = 0;
    int wait_n = 0;
    logic m_ifack = 1'b0;
    logic m_dack = 1'b0;
    logic [1:0] c_own = O_NONE;
    logic [31:0] c_addr = 32'd0;
    logic [31:0] c_wdata = 32'd0;
    logic [3:0] c_be = 4'd0;
    logic c_we = 1'b0;
    logic p_if, p_d, p_ready, p_dwe;
    logic [31:0] p_ifaddr, p_daddr, p_dwdata, p_rdata;
    logic [3:0] p_dbe;
    logic [1:0] win, exp_own;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      p_if = if_req; p_d = d_req; p_ready = mem_ready; p_dwe = d_we;
      p_ifaddr = if_addr; p_daddr = d_addr; p_dwdata = d_wdata; p_dbe = d_be; p_rdata = mem_rdata;
      tick();
      if (c_own == O_NONE) begin
        if (p_d && p_if) win = (st < SMAX) ? O_D : O_IF;
        else if (p_d) win = O_D;
        else if (p_if) win = O_IF;
        else win = O_NONE;
        exp_own = ((win == O_D && m_dack) || (win == O_IF && m_ifack)) ? O_NONE : win;
        m_ifack = 1'b0; m_dack = 1'b0;
        checks++;
        if (owner !== exp_own || mem_req !== (exp_own != O_NONE) || if_ack !== 1'b0 || d_ack !== 1'b0) begin
          errors++;
          $display("FAIL rand_arb cyc=%0d own=%b req=%b acks=%b%b want own=%b", cyc,
                   owner, mem_req, if_ack, d_ack, exp_own);
        end
        if (exp_own == O_D) begin
          if (p_if && st < SMAX) st++;
          c_addr = {p_daddr[31:2], 2'b00}; c_we = p_dwe; c_be = p_dwe ? p_dbe : 4'hF; c_wdata = p_dwdata;
        end else if (exp_own == O_IF) begin
          st = 0;
          c_addr = {p_ifaddr[31:2], 2'b00}; c_we = 1'b0; c_be = 4'hF;
        end
        if (exp_own != O_NONE) begin
          checks++;
          if (mem_addr !== c_addr || mem_we !== c_we || mem_be !== c_be || (c_we && mem_wdata !== c_wdata)) begin
            errors++;
            $display("FAIL rand_cmd cyc=%0d addr=%h we=%b be=%h wd=%h want %h/%b/%h/%h", cyc,
                     mem_addr, mem_we, mem_be, mem_wdata, c_addr, c_we, c_be, c_wdata);
          end
        end
        c_own = exp_own;
      end else if (p_ready) begin
        if (c_own == O_IF) begin
          exp_if_rdata = p_rdata; m_ifack = 1'b1;
        end else begin
          if (!c_we) exp_d_rdata = p_rdata;
          m_dack = 1'b1;
        end
        checks++;
        if (mem_req !== 1'b0 || owner !== O_NONE || if_ack !== m_ifack || d_ack !== m_dack ||
            if_err !== 1'b0 || d_err !== 1'b0 || if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
          errors++;
          $display("FAIL rand_ack cyc=%0d req=%b acks=%b%b errs=%b%b ird=%h drd=%h want acks=%b%b ird=%h drd=%h",
                   cyc, mem_req, if_ack, d_ack, if_err, d_err, if_rdata, d_rdata,
                   m_ifack, m_dack, exp_if_rdata, exp_d_rdata);
        end
        c_own = O_NONE;
      end else begin
        checks++;
        if (mem_req !== 1'b1 || owner !== c_own || mem_addr !== c_addr || mem_we !== c_we ||
            mem_be !== c_be || (c_we && mem_wdata !== c_wdata) || if_ack !== 1'b0 || d_ack !== 1'b0) begin
          errors++;
          $display("FAIL rand_hold cyc=%0d req=%b own=%b addr=%h want own=%b addr=%h", cyc,
                   mem_req, owner, mem_addr, c_own, c_addr);
        end
      end
      mem_rdata = $urandom;
      if (c_own != O_NONE) begin
        wait_n++;
        mem_ready = (wait_n >= 5) || ($urandom_range(0, 2) == 0);
      end else begin
        wait_n = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (m_ifack || !if_req) begin
        if_req = m_ifack ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end
      if (m_dack || !d_req) begin
        d_req = m_dack ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
        d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
